// File: rtl/cae_layer_sched_pkg.sv
// rtl/cae_layer_sched_pkg.sv - shared constants for the CAE layer sequencer
`ifndef FC_WCOL_WIDTH
`define FC_WCOL_WIDTH 8
`endif

package cae_layer_sched_pkg;
  localparam int CAE_FC_WCOL_WIDTH = `FC_WCOL_WIDTH;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_CONV_FETCH = 3'd1;
  localparam logic [2:0] ST_CONV_RUN   = 3'd2;
  localparam logic [2:0] ST_FC_FETCH   = 3'd3;
  localparam logic [2:0] ST_FC_RUN     = 3'd4;
  localparam logic [2:0] ST_FIN        = 3'd5;

  localparam logic LAYER_CONV = 1'b0;
  localparam logic LAYER_FC   = 1'b1;

  function automatic logic is_run(input logic [2:0] s);
    return (s == ST_CONV_RUN) || (s == ST_FC_RUN);
  endfunction
endpackage

// File: rtl/cae_layer_sched_if.sv
// rtl/cae_layer_sched_if.sv - operand fetch and core control bundle
interface cae_layer_sched_if #(
  parameter int ADDR_W        = 9,
  parameter int FC_WCOL_WIDTH = 8
);
  logic                     fetch_req;
  logic [ADDR_W-1:0]        fetch_addr;
  logic                     fetch_ack;
  logic                     core_enable;
  logic                     core_layer;
  logic [FC_WCOL_WIDTH-1:0] core_fc_wcol;
  logic                     conv_comp;
  logic                     fc_line_done;
  logic                     fc_done;
  logic                     res_valid;

  modport master (
    output fetch_req, fetch_addr, core_enable, core_layer, core_fc_wcol, res_valid,
    input  fetch_ack, conv_comp, fc_line_done, fc_done
  );
  modport slave (
    input  fetch_req, fetch_addr, core_enable, core_layer, core_fc_wcol, res_valid,
    output fetch_ack, conv_comp, fc_line_done, fc_done
  );
endinterface

// File: rtl/cae_wdog.sv
// rtl/cae_wdog.sv - clearable cycle counter with terminal-count flag
module cae_wdog #(
  parameter int          W     = 16,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic clk_i,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt_q, cnt_d;

  // tc fires on the LIMIT-th enabled cycle after a clear
  assign tc = en && (cnt_q == LIMIT - W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)            cnt_d = '0;
    else if (en && !tc) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cae_layer_sched.sv
// rtl/cae_layer_sched.sv - conv-then-FC pass sequencer for the CAE core
module cae_layer_sched
  import cae_layer_sched_pkg::*;
#(
  parameter int                ROW_CNT_W     = 8,
  parameter int                FC_WCOL_WIDTH = CAE_FC_WCOL_WIDTH,
  parameter int                ADDR_W        = 9,
  parameter int                WDOG_W        = 16,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT    = 16'hFFFF
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ROW_CNT_W-1:0]   cfg_conv_rows,
  input  logic [FC_WCOL_WIDTH:0] cfg_fc_cols,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  cae_layer_sched_if.master      bus
);
  localparam int CW = FC_WCOL_WIDTH + 1;

  logic [2:0]               state_q, state_d;
  logic [ROW_CNT_W-1:0]     rows_q, rows_d, row_q, row_d;
  logic [CW-1:0]            cols_q, cols_d, col_q, col_d;
  logic                     err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic                     fetch_req_q, fetch_req_d, core_enable_q, core_enable_d;
  logic                     core_layer_q, core_layer_d;
  logic [ADDR_W-1:0]        fetch_addr_q, fetch_addr_d;
  logic [FC_WCOL_WIDTH-1:0] core_fc_wcol_q, core_fc_wcol_d;
  logic                     in_run, run_clr, wdog_tc;

  assign in_run  = is_run(state_q);
  assign run_clr = !in_run;

  cae_wdog #(.W(WDOG_W), .LIMIT(WDOG_LIMIT)) u_wdog (
    .clk_i (clk_i),
    .rst   (rst),
    .clr   (run_clr),
    .en    (in_run),
    .tc    (wdog_tc)
  );

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    row_d   = row_q;
    col_d   = col_q;
    err_d   = err_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          rows_d = cfg_conv_rows;
          cols_d = cfg_fc_cols;
          row_d  = '0;
          col_d  = '0;
          err_d  = 1'b0;
          if (cfg_conv_rows != '0)    state_d = ST_CONV_FETCH;
          else if (cfg_fc_cols != '0) state_d = ST_FC_FETCH;
          else                        state_d = ST_FIN;
        end
        ST_CONV_FETCH: if (bus.fetch_ack) state_d = ST_CONV_RUN;
        ST_CONV_RUN: begin
          // a completion in the same cycle as the watchdog limit still counts
          if (bus.conv_comp) begin
            row_d = row_q + ROW_CNT_W'(1);
            if (row_q == rows_q - ROW_CNT_W'(1))
              state_d = (cols_q != '0) ? ST_FC_FETCH : ST_FIN;
            else
              state_d = ST_CONV_FETCH;
          end else if (wdog_tc) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
        ST_FC_FETCH: if (bus.fetch_ack) state_d = ST_FC_RUN;
        ST_FC_RUN: begin
          if (bus.fc_line_done) begin
            col_d   = col_q + CW'(1);
            state_d = ((col_q == cols_q - CW'(1)) || bus.fc_done) ? ST_FIN : ST_FC_FETCH;
          end else if (bus.fc_done) begin
            state_d = ST_FIN;
          end else if (wdog_tc) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state so they change on the same edge as the state
  always_comb begin
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_FIN);
    fetch_req_d    = (state_d == ST_CONV_FETCH) || (state_d == ST_FC_FETCH);
    core_enable_d  = is_run(state_d);
    core_layer_d   = ((state_d == ST_FC_FETCH) || (state_d == ST_FC_RUN)) ? LAYER_FC : LAYER_CONV;
    core_fc_wcol_d = (core_layer_d == LAYER_FC) ? col_d[FC_WCOL_WIDTH-1:0] : '0;
    fetch_addr_d   = '0;
    if (state_d == ST_CONV_FETCH) begin
      fetch_addr_d             = ADDR_W'(row_d);
      fetch_addr_d[ADDR_W-1]   = LAYER_CONV;
    end else if (state_d == ST_FC_FETCH) begin
      fetch_addr_d             = ADDR_W'(col_d[FC_WCOL_WIDTH-1:0]);
      fetch_addr_d[ADDR_W-1]   = LAYER_FC;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      rows_q         <= '0;
      cols_q         <= '0;
      row_q          <= '0;
      col_q          <= '0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      fetch_req_q    <= 1'b0;
      fetch_addr_q   <= '0;
      core_enable_q  <= 1'b0;
      core_layer_q   <= 1'b0;
      core_fc_wcol_q <= '0;
    end else begin
      state_q        <= state_d;
      rows_q         <= rows_d;
      cols_q         <= cols_d;
      row_q          <= row_d;
      col_q          <= col_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      fetch_req_q    <= fetch_req_d;
      fetch_addr_q   <= fetch_addr_d;
      core_enable_q  <= core_enable_d;
      core_layer_q   <= core_layer_d;
      core_fc_wcol_q <= core_fc_wcol_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign bus.fetch_req    = fetch_req_q;
  assign bus.fetch_addr   = fetch_addr_q;
  assign bus.core_enable  = core_enable_q;
  assign bus.core_layer   = core_layer_q;
  assign bus.core_fc_wcol = core_fc_wcol_q;
  assign bus.res_valid    = !abort && (((state_q == ST_CONV_RUN) && bus.conv_comp) ||
                                       ((state_q == ST_FC_RUN) && bus.fc_line_done));
endmodule

// File: tb/tb_cae_layer_sched.sv
// tb/tb_cae_layer_sched.sv - randomized self-checking bench for cae_layer_sched
module tb_cae_layer_sched;
  localparam int WD = 16;

  logic       clk_i = 1'b0;
  logic       rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] cfg_conv_rows = '0;
  logic [8:0] cfg_fc_cols = '0;
  logic       busy, done, err;

  cae_layer_sched_if #(.ADDR_W(9), .FC_WCOL_WIDTH(8)) bus ();

  cae_layer_sched #(
    .ROW_CNT_W(8), .FC_WCOL_WIDTH(8), .ADDR_W(9), .WDOG_W(16), .WDOG_LIMIT(16'd16)
  ) dut (
    .clk_i(clk_i), .rst(rst), .start(start), .abort(abort),
    .cfg_conv_rows(cfg_conv_rows), .cfg_fc_cols(cfg_fc_cols),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0, errors = 0;
  bit   chk_on = 1'b0;
  bit   exp_busy, exp_req, exp_en, exp_layer, exp_done, exp_err, exp_rv;
  logic [8:0] exp_addr;
  logic [7:0] exp_wcol;

  int   rv_cnt, done_cnt, busy_cnt;
  bit   err_seen;
  logic prev_req = 1'b0;
  logic [8:0] addr_q[$];
  logic [8:0] t1_addr[5] = '{9'h000, 9'h001, 9'h002, 9'h100, 9'h101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk_i) if (chk_on) begin
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("err", 32'(err), 32'(exp_err));
    chk("fetch_req", 32'(bus.fetch_req), 32'(exp_req));
    chk("core_enable", 32'(bus.core_enable), 32'(exp_en));
    chk("res_valid", 32'(bus.res_valid), 32'(exp_rv));
    if (exp_req) chk("fetch_addr", 32'(bus.fetch_addr), 32'(exp_addr));
    if (exp_req || exp_en) chk("core_layer", 32'(bus.core_layer), 32'(exp_layer));
    if ((exp_req || exp_en) && exp_layer) chk("core_fc_wcol", 32'(bus.core_fc_wcol), 32'(exp_wcol));
  end

  always @(negedge clk_i) begin
    if (bus.res_valid) rv_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (err) err_seen = 1'b1;
    if (bus.fetch_req && !prev_req) addr_q.push_back(bus.fetch_addr);
    prev_req = bus.fetch_req;
  end

  task automatic clr_mon();
    rv_cnt = 0; done_cnt = 0; busy_cnt = 0; err_seen = 1'b0; addr_q.delete();
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
    bus.fetch_ack = 1'b0; bus.conv_comp = 1'b0; bus.fc_line_done = 1'b0; bus.fc_done = 1'b0;
    exp_rv = 1'b0;
  endtask

  task automatic expect_out(input bit b, input bit rq, input logic [8:0] a, input bit en,
                            input bit ly, input logic [7:0] wc, input bit dn);
    exp_busy = b; exp_req = rq; exp_addr = a; exp_en = en; exp_layer = ly; exp_wcol = wc; exp_done = dn;
  endtask

  task automatic fin(input bit e);
    start = 1'b0; exp_err = e;
    expect_out(1, 0, 9'h0, 0, 0, 8'h0, 1); tick();
    expect_out(0, 0, 9'h0, 0, 0, 8'h0, 0); tick();
  endtask

  task automatic fetch_phase(input bit ly, input int idx, input int ack_d, input bit nz);
    logic [8:0] a;
    a = ly ? (9'h100 + 9'(idx)) : 9'(idx);
    for (int k = 0; k <= ack_d; k++) begin
      expect_out(1, 1, a, 0, ly, ly ? 8'(idx) : 8'h0, 0);
      bus.fetch_ack = (k == ack_d);
      if (nz) begin
        bus.conv_comp = 1'($urandom); bus.fc_line_done = 1'($urandom); bus.fc_done = 1'($urandom);
      end
      tick();
    end
  endtask

  // One complete pass; the bench plays memory and core, so every cycle's outputs are known.
  task automatic do_pass(input int rows, input int cols, input int ack_d, input int conv_d,
                         input int fc_d, input int fcd_col, input int fcd_mode,
                         input int stall_row, input int abort_row, input bit hold, input bit nz);
    cfg_conv_rows = 8'(rows); cfg_fc_cols = 9'(cols);
    start = 1'b1; expect_out(0, 0, 9'h0, 0, 0, 8'h0, 0); tick();
    start = hold; exp_err = 1'b0;
    for (int r = 0; r < rows; r++) begin
      fetch_phase(1'b0, r, ack_d, nz);
      for (int k = 0; ; k++) begin
        bit comp;
        expect_out(1, 0, 9'h0, 1, 0, 8'h0, 0);
        if (r == abort_row && k == 1) begin
          abort = 1'b1; start = 1'b0; tick(); abort = 1'b0;
          expect_out(0, 0, 9'h0, 0, 0, 8'h0, 0); tick();
          return;
        end
        comp = (k == conv_d) && (r != stall_row);
        bus.conv_comp = comp; exp_rv = comp;
        if (nz) begin
          bus.fetch_ack = 1'($urandom); bus.fc_line_done = 1'($urandom); bus.fc_done = 1'($urandom);
        end
        if (!comp && k == WD - 1) begin tick(); fin(1'b1); return; end
        tick();
        if (comp) break;
      end
    end
    if (cols == 0) begin fin(1'b0); return; end
    for (int c = 0; c < cols; c++) begin
      fetch_phase(1'b1, c, ack_d, nz);
      for (int k = 0; ; k++) begin
        bit line, fd;
        expect_out(1, 0, 9'h0, 1, 1, 8'(c), 0);
        line = (k == fc_d); fd = 1'b0;
        if (c == fcd_col && k == fc_d) begin
          fd = (fcd_mode != 0);
          if (fcd_mode == 2) line = 1'b0;
        end
        bus.fc_line_done = line; bus.fc_done = fd; exp_rv = line;
        if (nz) begin bus.fetch_ack = 1'($urandom); bus.conv_comp = 1'($urandom); end
        if (!line && !fd && k == WD - 1) begin tick(); fin(1'b1); return; end
        tick();
        if (fd) begin fin(1'b0); return; end
        if (line) break;
      end
    end
    fin(1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bus.fetch_ack = 1'b0; bus.conv_comp = 1'b0; bus.fc_line_done = 1'b0; bus.fc_done = 1'b0;
    expect_out(0, 0, 9'h0, 0, 0, 8'h0, 0); exp_err = 1'b0; exp_rv = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst = 1'b0;
    tick();

    clr_mon(); do_pass(3, 2, 2, 5, 4, -1, 0, -1, -1, 1'b0, 1'b0);
    chk("t1_naddr", 32'(addr_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("t1_addr", 32'((i < addr_q.size()) ? addr_q[i] : 9'h1ff), 32'(t1_addr[i]));
    chk("t1_rv", 32'(rv_cnt), 32'd5);
    chk("t1_done", 32'(done_cnt), 32'd1);

    clr_mon(); do_pass(0, 0, 0, 0, 0, -1, 0, -1, -1, 1'b0, 1'b0);
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd1);
    chk("t2_done", 32'(done_cnt), 32'd1);
    chk("t2_nreq", 32'(addr_q.size()), 32'd0);

    clr_mon(); do_pass(2, 4, 1, 3, 2, 1, 1, -1, -1, 1'b0, 1'b0);
    chk("t3_rv", 32'(rv_cnt), 32'd4);
    chk("t3_done", 32'(done_cnt), 32'd1);

    clr_mon(); do_pass(3, 1, 1, 5, 2, -1, 0, -1, 1, 1'b0, 1'b0);
    chk("t4_done", 32'(done_cnt), 32'd0);
    chk("t4_rv", 32'(rv_cnt), 32'd1);
    clr_mon(); do_pass(1, 1, 0, 2, 2, -1, 0, -1, -1, 1'b0, 1'b0);
    chk("t4_restart_addr", 32'((addr_q.size() > 0) ? addr_q[0] : 9'h1ff), 32'h000);

    clr_mon(); do_pass(2, 1, 1, 3, 2, -1, 0, 0, -1, 1'b0, 1'b0);
    chk("t5_err", 32'(err_seen), 32'd1);
    chk("t5_done", 32'(done_cnt), 32'd1);
    chk("t5_busy_cycles", 32'(busy_cnt), 32'd19);
    clr_mon(); do_pass(1, 1, 0, 1, 1, -1, 0, -1, -1, 1'b0, 1'b0);
    chk("t5_err_clear", 32'(err), 32'd0);

    clr_mon(); do_pass(3, 2, 2, 5, 4, -1, 0, -1, -1, 1'b1, 1'b1);
    chk("t6_naddr", 32'(addr_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("t6_addr", 32'((i < addr_q.size()) ? addr_q[i] : 9'h1ff), 32'(t1_addr[i]));
    chk("t6_rv", 32'(rv_cnt), 32'd5);

    clr_mon(); do_pass(1, 3, 1, 2, 3, 1, 2, -1, -1, 1'b0, 1'b0);
    chk("t7_rv", 32'(rv_cnt), 32'd2);
    chk("t7_done", 32'(done_cnt), 32'd1);

    for (int n = 0; n < 40; n++) begin
      int rows, cols, ack_d, conv_d, fc_d, fcd_col, fcd_mode, stall_row, abort_row;
      rows      = $urandom_range(0, 4);
      cols      = $urandom_range(0, 4);
      ack_d     = $urandom_range(0, 3);
      conv_d    = $urandom_range(0, 6);
      fc_d      = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 5);
      fcd_col   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      fcd_mode  = $urandom_range(1, 2);
      stall_row = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
      abort_row = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
      do_pass(rows, cols, ack_d, conv_d, fc_d, fcd_col, fcd_mode, stall_row, abort_row,
              1'($urandom), 1'($urandom));
    end

    cfg_conv_rows = 8'd2; cfg_fc_cols = 9'd2;
    start = 1'b1; tick(); start = 1'b0;
    chk_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
    chk("rst_core_enable", 32'(bus.core_enable), 32'd0);
    tick(); rst = 1'b0;
    expect_out(0, 0, 9'h0, 0, 0, 8'h0, 0); exp_err = 1'b0; chk_on = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
